// File: rtl/game_pkg.sv
// Shared screen geometry, position width and game state encoding for the
// obstacle spawner and its slots.
package game_pkg;

  localparam int POS_W = 10;

  localparam logic [POS_W-1:0] VBP       = 10'd31;
  localparam logic [POS_W-1:0] VFP       = 10'd511;
  localparam logic [POS_W-1:0] HBP       = 10'd295;
  localparam logic [POS_W-1:0] LANE_STEP = 10'd120;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

// File: rtl/obstacle_slot.sv
// One falling obstacle: load on spawn, advance per frame, retire past the
// bottom of the active area, and report a per-slot player overlap term.
module obstacle_slot
  import game_pkg::*;
#(
  parameter int OBJ_H       = 32,
  parameter int PLAYER_VPOS = 447
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             load,
  input  logic [POS_W-1:0] load_hpos,
  input  logic [3:0]       speed,
  input  logic [POS_W-1:0] player_hpos,
  output logic             active,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             retire,
  output logic             hit
);

  localparam logic [POS_W:0] OBJ_H_W  = (POS_W+1)'(OBJ_H);
  localparam logic [POS_W:0] PLAYER_W = (POS_W+1)'(PLAYER_VPOS);

  logic [POS_W:0] vpos_next;

  // Sums are one bit wider than a position so nothing wraps near the bottom.
  assign vpos_next = {1'b0, vpos} + {{(POS_W-3){1'b0}}, speed};
  assign retire    = active && adv && (vpos_next >= {1'b0, VFP});
  assign hit       = active && (hpos == player_hpos) &&
                     (({1'b0, vpos} + OBJ_H_W) > PLAYER_W);

  always_ff @(posedge clk) begin
    if (!rst || clr || retire) begin
      active <= 1'b0;
      hpos   <= '0;
      vpos   <= '0;
    end else if (load) begin
      active <= 1'b1;
      hpos   <= load_hpos;
      vpos   <= VBP;
    end else if (adv && active) begin
      vpos <= vpos_next[POS_W-1:0];
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Spawns, advances and retires falling obstacles and detects player hits.
// Optional macro OBSTACLE_SPEEDUP_EN: fall speed grows by 1 every 8 spawns.
module obstacle_spawner
  import game_pkg::*;
#(
  parameter int NSLOT        = 4,
  parameter int SPAWN_FRAMES = 30,
  parameter int BASE_SPEED   = 2,
  parameter int OBJ_H        = 32,
  parameter int PLAYER_VPOS  = 447
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   frame_tick,
  input  logic [POS_W-1:0]       rand_hpos,
  input  logic [POS_W-1:0]       player_hpos,
  output logic [NSLOT-1:0]       obj_active,
  output logic [NSLOT*POS_W-1:0] obj_hpos,
  output logic [NSLOT*POS_W-1:0] obj_vpos,
  output logic [15:0]            score,
  output logic [7:0]             dropped,
  output logic                   running,
  output logic                   game_over
);

  localparam int CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPAWN_FRAMES - 1);

  state_t           state;
  logic [CNT_W-1:0] spawn_cnt;
  logic             hit_q;
  logic             enter_run;
  logic             adv;
  logic             spawn_try;
  logic             any_free;
  logic [3:0]       speed;
  logic [NSLOT-1:0] load_vec;
  logic [NSLOT-1:0] retire_vec;
  logic [NSLOT-1:0] hit_vec;
  logic [16:0]      retire_cnt;
  logic [16:0]      score_sum;

  assign enter_run = start && (state != RUN);
  assign adv       = (state == RUN) && frame_tick;
  assign spawn_try = adv && (spawn_cnt == '0);
  assign any_free  = |(~obj_active);

  // Free mask is taken before this tick's retirements land.
  always_comb begin
    load_vec = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (spawn_try && !obj_active[i]) begin
        load_vec    = '0;
        load_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < NSLOT; i++) begin
      retire_cnt = retire_cnt + 17'(retire_vec[i]);
    end
    score_sum = {1'b0, score} + retire_cnt;
  end

`ifdef OBSTACLE_SPEEDUP_EN
  logic [2:0] spawn_ok_cnt;

  always_ff @(posedge clk) begin
    if (!rst || enter_run) begin
      spawn_ok_cnt <= '0;
      speed        <= 4'(BASE_SPEED);
    end else if (spawn_try && any_free) begin
      spawn_ok_cnt <= spawn_ok_cnt + 3'd1;
      if (spawn_ok_cnt == 3'd7 && speed != 4'd15) speed <= speed + 4'd1;
    end
  end
`else
  assign speed = 4'(BASE_SPEED);
`endif

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    obstacle_slot #(
      .OBJ_H      (OBJ_H),
      .PLAYER_VPOS(PLAYER_VPOS)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .clr        (enter_run),
      .adv        (adv),
      .load       (load_vec[i]),
      .load_hpos  (rand_hpos),
      .speed      (speed),
      .player_hpos(player_hpos),
      .active     (obj_active[i]),
      .hpos       (obj_hpos[i*POS_W +: POS_W]),
      .vpos       (obj_vpos[i*POS_W +: POS_W]),
      .retire     (retire_vec[i]),
      .hit        (hit_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      spawn_cnt <= '0;
      hit_q     <= 1'b0;
      score     <= '0;
      dropped   <= '0;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else if (enter_run) begin
      state     <= RUN;
      spawn_cnt <= CNT_RELOAD;
      hit_q     <= 1'b0;
      score     <= '0;
      dropped   <= '0;
      running   <= 1'b1;
      game_over <= 1'b0;
    end else if (state == RUN) begin
      hit_q <= |hit_vec;
      if (hit_q) begin
        state     <= OVER;
        running   <= 1'b0;
        game_over <= 1'b1;
      end
      if (adv) begin
        spawn_cnt <= (spawn_cnt == '0) ? CNT_RELOAD : spawn_cnt - CNT_W'(1);
        score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (spawn_try && !any_free && dropped != 8'hFF) dropped <= dropped + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: one default instance plus two
// fast-spawn instances sharing the same stimulus.
module tb_obstacle_spawner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        frame_tick;
  logic [9:0]  rand_hpos;
  logic [9:0]  player_hpos;

  logic [3:0]  act_a, act_b, act_c;
  logic [39:0] hpos_a, hpos_b, hpos_c;
  logic [39:0] vpos_a, vpos_b, vpos_c;
  logic [15:0] score_a, score_b, score_c;
  logic [7:0]  drop_a, drop_b, drop_c;
  logic        run_a, run_b, run_c;
  logic        over_a, over_b, over_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  obstacle_spawner u_dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .rand_hpos(rand_hpos), .player_hpos(player_hpos),
    .obj_active(act_a), .obj_hpos(hpos_a), .obj_vpos(vpos_a),
    .score(score_a), .dropped(drop_a), .running(run_a), .game_over(over_a)
  );

  obstacle_spawner #(.SPAWN_FRAMES(1), .BASE_SPEED(1)) u_fast (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .rand_hpos(rand_hpos), .player_hpos(player_hpos),
    .obj_active(act_b), .obj_hpos(hpos_b), .obj_vpos(vpos_b),
    .score(score_b), .dropped(drop_b), .running(run_b), .game_over(over_b)
  );

  obstacle_spawner #(.SPAWN_FRAMES(1), .BASE_SPEED(2)) u_spd (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .rand_hpos(rand_hpos), .player_hpos(player_hpos),
    .obj_active(act_c), .obj_hpos(hpos_c), .obj_vpos(vpos_c),
    .score(score_c), .dropped(drop_c), .running(run_c), .game_over(over_c)
  );

  typedef struct {
    int         n;
    logic [9:0] rnd;
    logic [3:0] act;
    int         vpos0;
    int         hpos0;
    int         score;
    int         dropped;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    if (n > 0) begin
      frame_tick = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{0,   10'd415, 4'b0000, 0,   0,   0, 0};
    vecs[1]  = '{29,  10'd415, 4'b0000, 0,   0,   0, 0};
    vecs[2]  = '{1,   10'd415, 4'b0001, 31,  415, 0, 0};
    vecs[3]  = '{1,   10'd415, 4'b0001, 33,  415, 0, 0};
    vecs[4]  = '{28,  10'd415, 4'b0001, 89,  415, 0, 0};
    vecs[5]  = '{1,   10'd535, 4'b0011, 91,  415, 0, 0};
    vecs[6]  = '{90,  10'd415, 4'b1111, 271, 415, 0, 1};
    vecs[7]  = '{119, 10'd415, 4'b1111, 509, 415, 0, 4};
    vecs[8]  = '{1,   10'd415, 4'b1110, 0,   0,   1, 5};
    vecs[9]  = '{1,   10'd415, 4'b1110, 0,   0,   1, 5};
    vecs[10] = '{29,  10'd535, 4'b1101, 31,  535, 2, 5};

    rst = 1'b0; start = 1'b0; frame_tick = 1'b0;
    rand_hpos = 10'd415; player_hpos = 10'd295;
    do_reset();
    chk("reset_active", act_a, 0);
    chk("reset_vpos",   (vpos_a == 40'd0) ? 1 : 0, 1);
    chk("reset_hpos",   (hpos_a == 40'd0) ? 1 : 0, 1);
    chk("reset_running", run_a, 0);
    chk("reset_over",   over_a, 0);

    // Frames in IDLE must not move anything.
    ticks(40);
    chk("idle_tick_active", act_a, 0);

    pulse_start();
    for (int i = 0; i < 11; i++) begin
      rand_hpos = vecs[i].rnd;
      ticks(vecs[i].n);
      chk($sformatf("v%0d_active", i),  act_a, vecs[i].act);
      chk($sformatf("v%0d_vpos0", i),   vpos_a[9:0], vecs[i].vpos0);
      chk($sformatf("v%0d_hpos0", i),   hpos_a[9:0], vecs[i].hpos0);
      chk($sformatf("v%0d_score", i),   score_a, vecs[i].score);
      chk($sformatf("v%0d_dropped", i), drop_a, vecs[i].dropped);
      chk($sformatf("v%0d_running", i), run_a, 1);
      chk($sformatf("v%0d_over", i),    over_a, 0);
    end

    // Hit pipeline: obstacle in the player's lane.
    do_reset();
    player_hpos = 10'd295;
    rand_hpos   = 10'd295;
    pulse_start();
    ticks(222);
    chk("hit_pre_vpos", vpos_a[9:0], 415);
    step();
    chk("hit_pre_over", over_a, 0);
    ticks(1);
    chk("hit_n_vpos", vpos_a[9:0], 417);
    chk("hit_n_over", over_a, 0);
    step();
    chk("hit_n1_over", over_a, 0);
    chk("hit_n1_running", run_a, 1);
    step();
    chk("hit_n2_over", over_a, 1);
    chk("hit_n2_running", run_a, 0);
    chk("hit_dropped", drop_a, 3);
    ticks(5);
    chk("over_frozen_vpos", vpos_a[9:0], 417);
    chk("over_frozen_active", act_a, 4'b1111);
    chk("over_frozen_dropped", drop_a, 3);

    // Restart with a coincident frame tick: tick is discarded.
    start = 1'b1; frame_tick = 1'b1;
    step();
    start = 1'b0; frame_tick = 1'b0;
    chk("restart_active", act_a, 0);
    chk("restart_vpos", (vpos_a == 40'd0) ? 1 : 0, 1);
    chk("restart_score", score_a, 0);
    chk("restart_dropped", drop_a, 0);
    chk("restart_running", run_a, 1);
    chk("restart_over", over_a, 0);
    ticks(29);
    chk("restart_29_active", act_a, 0);
    ticks(1);
    chk("restart_30_active", act_a, 4'b0001);

    // Fast-spawn instances: fill all slots, then drop.
    do_reset();
    player_hpos = 10'd0;
    rand_hpos   = 10'd415;
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      ticks(1);
      chk($sformatf("fast_t%0d_active", i), act_b, (i >= 4) ? 15 : ((1 << i) - 1));
      chk($sformatf("fast_t%0d_dropped", i), drop_b, (i == 5) ? 1 : 0);
    end
    chk("fast_vpos0", vpos_b[9:0], 35);

    // Speed instance: the 8th successful spawn lands on tick 245.
    ticks(240);
    chk("spd_pre_vpos0", vpos_c[9:0], 37);
    ticks(1);
`ifdef OBSTACLE_SPEEDUP_EN
    chk("spd_delta", vpos_c[9:0], 40);
`else
    chk("spd_delta", vpos_c[9:0], 39);
`endif

    // Reset in mid-game clears everything.
    rst = 1'b0;
    step();
    chk("midrst_active", act_c, 0);
    chk("midrst_hpos", (hpos_c == 40'd0) ? 1 : 0, 1);
    chk("midrst_running", run_c, 0);
    chk("midrst_dropped", drop_c, 0);
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Consumer of the LFSR lane generator: samples `rand_hpos` on a spawn interval, allocates falling obstacles into a fixed pool of slots, advances them once per video frame, retires them at the bottom of the active area, and flags a collision with the player. It sits between the random generator and the VGA pixel renderer, which reads the slot outputs.

## Interface
- `NSLOT`, 4: number of obstacle slots.
- `SPAWN_FRAMES`, 30: frames between spawn attempts (≥1).
- `BASE_SPEED`, 2: pixels per frame an obstacle falls (1..15).
- `OBJ_H`, 32: obstacle height in pixels.
- `PLAYER_VPOS`, 447: top line of the player sprite.

- `clk`  in  1  system/pixel clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a game.
- `frame_tick`  in  1  one-cycle pulse per frame (vsync edge).
- `rand_hpos`  in  10  lane x-position from the generator (295/415/535).
- `player_hpos`  in  10  player lane x-position.
- `obj_active`  out  NSLOT  slot i holds a live obstacle.
- `obj_hpos`  out  NSLOT×10  packed x-positions, slot 0 in LSBs.
- `obj_vpos`  out  NSLOT×10  packed top-line y-positions.
- `score`  out  16  obstacles retired without collision.
- `dropped`  out  8  spawn attempts lost because all slots were full; saturates at 255.
- `running`  out  1  high in RUN.
- `game_over`  out  1  high in OVER.

## Operation
- States: IDLE → RUN on `start`; RUN → OVER on a registered hit; OVER → RUN on `start`. `start` in RUN is ignored.
- Entering RUN clears all slots, `score`, `dropped`, and speed state, and loads the spawn counter with `SPAWN_FRAMES-1`.
- In RUN, on each `frame_tick`:
  - Every active slot advances `vpos += speed`. A slot whose new `vpos` ≥ 511 is cleared, and `score` increments by the number retired that tick, saturating at 65535.
  - The spawn counter decrements. At 0 it reloads `SPAWN_FRAMES-1` and a spawn is attempted. The spawn goes to the lowest-index slot that was free *before* this tick's retirements, with `hpos = rand_hpos` sampled that cycle and `vpos = 31`.
  - If no slot is free, `dropped` increments.
- Hit detection runs every cycle in RUN. Hit if any slot has `active`, `hpos == player_hpos`, and `vpos + OBJ_H > PLAYER_VPOS`. Compute the sum in 11 bits.
- In OVER, slots, `score`, and `dropped` freeze and remain visible. `frame_tick` has no effect.
- `frame_tick` in IDLE has no effect.

## Timing
- Reset (`rst`=0 at a `clk` edge): state IDLE; all outputs 0, including `obj_hpos`/`obj_vpos`.
- All outputs are registered.
- Slot updates are visible the cycle after the `frame_tick` cycle.
- Hit pipeline: a hit condition at cycle N sets the internal hit flag at N+1, and `game_over`=1 / `running`=0 at N+2.
- A slot retired and a spawn on the same tick: the freed slot is not reused until the next spawn attempt.
- `start` and `frame_tick` in the same cycle: `start` wins and the tick is discarded.
- Reset asserted mid-game overrides everything in that cycle.

## Configuration
- `OBSTACLE_SPEEDUP_EN` defined: speed starts at `BASE_SPEED` and increases by 1 after every 8 successful spawns, capped at 15. A 3-bit spawn counter and a 4-bit speed register are reset on entering RUN.
- Not defined: speed is the constant `BASE_SPEED`, and no speed register or counter exists.

## Structure
- Package `game_pkg` holds:
  - screen constants `VBP`=31, `VFP`=511, `HBP`=295, `LANE_STEP`=120;
  - the state enum `{IDLE, RUN, OVER}`;
  - the position width `POS_W`=10.
- One sub-module, `obstacle_slot`: holds `active`/`hpos`/`vpos`, handles load, advance, and retire, and outputs per-slot `retire` and `hit` terms. It is instantiated NSLOT times.
- Allocation (priority encoder over the free mask), counters, and the FSM live in the top.

## Test plan
- Reset, then `start`, then 30 `frame_tick`s with `rand_hpos`=415 → slot 0 active, hpos 415, vpos 31; `obj_active`=4'b0001.
- Run with `player_hpos`=295 and lanes ≠295 until the first obstacle passes 511 at speed 2 → slot 0 cleared on that tick; `score`=1; `game_over` stays 0.
- `SPAWN_FRAMES`=1, `BASE_SPEED`=1, 5 ticks → slots 0–3 filled and the 5th attempt drops; `dropped`=1.
- Obstacle in lane 295 with `player_hpos`=295 → `game_over`=1 exactly 2 cycles after vpos+32 first exceeds 447; positions frozen on later ticks.
- `start` coincident with `frame_tick` during OVER → all slots 0, `score`=0, `running`=1, no advance.
- With `OBSTACLE_SPEEDUP_EN`: after 8 spawns the per-tick vpos delta goes from 2 to 3. Without the macro it stays 2.
